// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 protocol constants and key-tracker state encoding
package ps2_pkg;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam int PS2_FRAME_BITS = 11;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BREAK = 1'b1;
endpackage

// File: rtl/ps2_fifo.sv
// ps2_fifo: byte FIFO with valid/ready pop; a push into a full FIFO without a pop is dropped and flagged sticky
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop_ready,
  output logic [7:0] data,
  output logic       valid,
  output logic       overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, pop, wr;
  assign valid = cnt_q != '0;
  assign data = valid ? mem_q[rd_ptr_q] : '0;
  assign overflow = ovf_q;
  always_comb begin
    pop = valid & pop_ready;
    wr = push & ((cnt_q != FULL_CNT) | pop);
    wr_ptr_d = wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovf_d = ovf_q | (push & ~wr);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      mem_q <= '{default: '0};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (wr) mem_q[wr_ptr_q] <= push_data;
    end
  end
endmodule

// File: rtl/ps2_key_ctrl.sv
// ps2_key_ctrl: PS/2 receiver, byte FIFO and key tracker; define PS2_PARITY_CHECK_EN to reject bad-parity frames
module ps2_key_ctrl
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] fifo_data,
  output logic       fifo_valid,
  input  logic       fifo_ready,
  output logic [7:0] key_code,
  output logic [7:0] key_count,
  output logic       key_valid,
  output logic       frame_err,
  output logic       overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0] BIT_LAST = 4'(PS2_FRAME_BITS - 1);
  logic [2:0] clk_sync_q, clk_sync_d, dat_sync_q, dat_sync_d;
  logic [9:0] frame_q, frame_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [0:0] state_q, state_d;
  logic [7:0] code_q, code_d, count_q, count_d, rx_byte;
  logic [10:0] word;
  logic valid_q, valid_d, err_q, err_d;
  logic fall, done, timeout, parity_ok, accept, is_brk, is_ext, press, release_hit;
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], ps2_clk};
    dat_sync_d = {dat_sync_q[1:0], ps2_data};
    fall = clk_sync_q[2] & ~clk_sync_q[1];
    // word is the full frame as it stands after this cycle's edge: [0]=start, [8:1]=data, [9]=parity, [10]=stop
    word = {dat_sync_q[2], frame_q};
    frame_d = fall ? word[10:1] : frame_q;
    done = fall & (bit_cnt_q == BIT_LAST);
    timeout = ~fall & (bit_cnt_q != '0) & (to_cnt_q == TO_LAST);
    bit_cnt_d = (done | timeout) ? '0 : fall ? bit_cnt_q + 4'd1 : bit_cnt_q;
    to_cnt_d = (fall | timeout | (bit_cnt_q == '0)) ? '0 : to_cnt_q + TW'(1);
    rx_byte = word[8:1];
`ifdef PS2_PARITY_CHECK_EN
    parity_ok = ^word[9:1];
`else
    parity_ok = 1'b1;
`endif
    accept = done & ~word[0] & word[10] & parity_ok;
    err_d = done & ~accept;
    is_brk = rx_byte == PS2_BREAK;
    is_ext = rx_byte == PS2_EXT;
    press = accept & (state_q == ST_IDLE) & ~is_brk & ~is_ext & ~(valid_q & (rx_byte == code_q));
    release_hit = accept & (state_q == ST_BREAK) & ~is_ext & (rx_byte == code_q);
    state_d = (accept & ~is_ext) ? (((state_q == ST_IDLE) & is_brk) ? ST_BREAK : ST_IDLE) : state_q;
    code_d = press ? rx_byte : code_q;
    count_d = press ? count_q + 8'd1 : count_q;
    valid_d = press | (valid_q & ~release_hit);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync_q <= '0;
      dat_sync_q <= '0;
      frame_q <= '0;
      bit_cnt_q <= '0;
      to_cnt_q <= '0;
      state_q <= ST_IDLE;
      code_q <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      frame_q <= frame_d;
      bit_cnt_q <= bit_cnt_d;
      to_cnt_q <= to_cnt_d;
      state_q <= state_d;
      code_q <= code_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  end
  assign key_code = code_q;
  assign key_count = count_q;
  assign key_valid = valid_q;
  assign frame_err = err_q;
  ps2_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(accept),
    .push_data(rx_byte),
    .pop_ready(fifo_ready),
    .data(fifo_data),
    .valid(fifo_valid),
    .overflow(overflow)
  );
endmodule

// File: tb/tb_ps2_key_ctrl.sv
// tb_ps2_key_ctrl: vector table, directed corner sequences and random frames checked against a queue-based model
`timescale 1ns/1ps
module tb_ps2_key_ctrl;
  localparam int DEPTH = 8;
  localparam int TO = 300;
  localparam int H = 4;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, fifo_ready = 1'b0;
  logic [7:0] fifo_data, key_code, key_count;
  logic fifo_valid, key_valid, frame_err, overflow;
  int total = 0, bad = 0, errcnt = 0, npop = 0;
  logic [7:0] q[$];
  bit bq[$];
  int m_errs;
  logic [7:0] m_code, m_count;
  bit m_valid, m_brk, m_ovf;
  typedef struct { logic [7:0] b; bit bs; bit bt; logic [7:0] code; logic [7:0] cnt; bit vld; } vec_t;
  vec_t tbl[17];
  always #5 clk = ~clk;
  ps2_key_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .key_code(key_code), .key_count(key_count), .key_valid(key_valid),
    .frame_err(frame_err), .overflow(overflow)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && frame_err) errcnt++;
    if (rst_n && fifo_valid && fifo_ready) begin
      npop++;
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL pop: got %h want <empty fifo>", fifo_data);
      end else begin
        if (fifo_data !== q[0]) begin
          bad++;
          $display("FAIL pop: got %h want %h", fifo_data, q[0]);
        end
        void'(q.pop_front());
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic model_reset();
    q.delete(); bq.delete();
    m_code = 0; m_count = 0; m_valid = 0; m_brk = 0; m_ovf = 0; m_errs = 0; errcnt = 0;
  endtask
  task automatic model_byte(input logic [7:0] b);
    if (q.size() < DEPTH) q.push_back(b); else m_ovf = 1;
    if (m_brk) begin
      if (b != 8'hE0) begin
        if (b == m_code) m_valid = 0;
        m_brk = 0;
      end
    end else if (b == 8'hF0) m_brk = 1;
    else if (b != 8'hE0 && (!m_valid || b != m_code)) begin
      m_count = m_count + 8'd1; m_code = b; m_valid = 1;
    end
  endtask
  task automatic model_frame();
    logic [10:0] f;
    for (int i = 0; i < 11; i++) f[i] = bq[i];
    bq.delete();
    if (!f[0] && f[10] && (!PAR_EN || (^f[9:1]))) model_byte(f[8:1]); else m_errs++;
  endtask
  task automatic drive_bit(input bit v);
    ps2_data = v;
    cyc(H);
    ps2_clk = 1'b0;
    bq.push_back(v);
    if (bq.size() == 11) model_frame();
    cyc(H);
    ps2_clk = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input bit bs, input bit bp, input bit bt, input int n);
    logic [10:0] f;
    f = {~bt, ~(^b) ^ bp, b, bs};
    for (int i = 0; i < n; i++) drive_bit(f[i]);
    cyc(H);
  endtask
  task automatic idle(input int n);
    cyc(n);
    if (n >= TO) bq.delete();
  endtask
  task automatic do_reset();
    rst_n = 1'b0; ps2_clk = 1'b1; ps2_data = 1'b1; fifo_ready = 1'b0;
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
  endtask
  task automatic check_all(input string tag);
    @(negedge clk);
    chk({tag, ".code"}, key_code, m_code);
    chk({tag, ".count"}, key_count, m_count);
    chk({tag, ".valid"}, key_valid, m_valid);
    chk({tag, ".ovf"}, overflow, m_ovf);
    chk({tag, ".fvalid"}, fifo_valid, 32'(q.size() != 0));
    chk({tag, ".errs"}, errcnt, m_errs);
    if (q.size() != 0) chk({tag, ".fdata"}, fifo_data, q[0]);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, ".fdata"}, fifo_data, 0);
    chk({tag, ".fvalid"}, fifo_valid, 0);
    chk({tag, ".code"}, key_code, 0);
    chk({tag, ".count"}, key_count, 0);
    chk({tag, ".valid"}, key_valid, 0);
    chk({tag, ".err"}, frame_err, 0);
    chk({tag, ".ovf"}, overflow, 0);
  endtask
  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 8'd1, 1'b1};
    tbl[1]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 8'd1, 1'b1};
    tbl[2]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 8'd1, 1'b1};
    tbl[3]  = '{8'hF0, 1'b0, 1'b0, 8'h1C, 8'd1, 1'b1};
    tbl[4]  = '{8'h1C, 1'b0, 1'b0, 8'h1C, 8'd1, 1'b0};
    tbl[5]  = '{8'h32, 1'b0, 1'b0, 8'h32, 8'd2, 1'b1};
    tbl[6]  = '{8'hE0, 1'b0, 1'b0, 8'h32, 8'd2, 1'b1};
    tbl[7]  = '{8'h32, 1'b0, 1'b0, 8'h32, 8'd2, 1'b1};
    tbl[8]  = '{8'h1C, 1'b0, 1'b1, 8'h32, 8'd2, 1'b1};
    tbl[9]  = '{8'h1C, 1'b1, 1'b0, 8'h32, 8'd2, 1'b1};
    tbl[10] = '{8'hF0, 1'b0, 1'b0, 8'h32, 8'd2, 1'b1};
    tbl[11] = '{8'hE0, 1'b0, 1'b0, 8'h32, 8'd2, 1'b1};
    tbl[12] = '{8'h1C, 1'b0, 1'b0, 8'h32, 8'd2, 1'b1};
    tbl[13] = '{8'h1C, 1'b0, 1'b0, 8'h1C, 8'd3, 1'b1};
    tbl[14] = '{8'hF0, 1'b0, 1'b0, 8'h1C, 8'd3, 1'b1};
    tbl[15] = '{8'h1C, 1'b0, 1'b0, 8'h1C, 8'd3, 1'b0};
    tbl[16] = '{8'h1C, 1'b0, 1'b0, 8'h1C, 8'd4, 1'b1};
    model_reset();
    @(negedge clk);
    chk_zero("reset");
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].b, tbl[i].bs, 1'b0, tbl[i].bt, 11);
      @(negedge clk);
      chk($sformatf("vec%0d.code", i), key_code, tbl[i].code);
      chk($sformatf("vec%0d.count", i), key_count, tbl[i].cnt);
      chk($sformatf("vec%0d.valid", i), key_valid, tbl[i].vld);
      check_all($sformatf("vec%0d", i));
    end
    npop = 0;
    fifo_ready = 1'b1;
    cyc(DEPTH + 4);
    fifo_ready = 1'b0;
    @(negedge clk);
    chk("drain.n", npop, DEPTH);
    check_all("drain");
    do_reset();
    send(8'h1C, 1'b0, 1'b1, 1'b0, 11);
    check_all("parity");
    chk("parity.count", key_count, PAR_EN ? 0 : 1);
    do_reset();
    send(8'h55, 1'b0, 1'b0, 1'b0, 4);
    idle(TO + 5);
    send(8'h32, 1'b0, 1'b0, 1'b0, 11);
    check_all("tmo");
    chk("tmo.fdata", fifo_data, 8'h32);
    chk("tmo.errs", errcnt, 0);
    send(8'h55, 1'b0, 1'b0, 1'b0, 4);
    idle(TO - 40);
    send(8'h32, 1'b0, 1'b0, 1'b0, 11);
    idle(TO + 5);
    check_all("notmo");
    send(8'h5A, 1'b0, 1'b0, 1'b0, 11);
    check_all("aftertmo");
    do_reset();
    send(8'h1C, 1'b0, 1'b0, 1'b0, 11);
    send(8'h32, 1'b0, 1'b0, 1'b0, 11);
    check_all("pre_rst");
    send(8'h5A, 1'b0, 1'b0, 1'b0, 5);
    #3 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    model_reset();
    cyc(2);
    rst_n = 1'b1;
    cyc(4);
    send(8'h5A, 1'b0, 1'b0, 1'b0, 11);
    check_all("post_rst");
    do_reset();
    for (int it = 0; it < 40; it++) begin
      logic [7:0] b;
      int sel, cor;
      sel = $urandom_range(0, 5);
      b = sel == 0 ? 8'hF0 : sel == 1 ? 8'hE0 : sel == 2 ? 8'h1C : sel == 3 ? 8'h32 : 8'($urandom);
      cor = $urandom_range(0, 11);
      send(b, cor == 0, cor == 1, cor == 2, 11);
      check_all($sformatf("rnd%0d", it));
      for (int k = $urandom_range(0, 10); k > 0; k--) begin
        fifo_ready = 1'($urandom_range(0, 1));
        cyc(1);
      end
      fifo_ready = 1'b0;
      cyc(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
